// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, with sign fix-up on the last iteration.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [5:0]       i_control,
  input  logic [WIDTH-1:0] i_op1,
  input  logic [WIDTH-1:0] i_op2,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic [1:0]         state;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   opb;
  logic [2*WIDTH-1:0] work;
  logic               neg_q;
  logic               neg_r;

  logic               is_signed;
  logic [WIDTH-1:0]   mag1;
  logic [WIDTH-1:0]   mag2;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] mul_final;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   quot_final;
  logic [WIDTH-1:0]   rem_final;

  // Magnitudes fit in WIDTH unsigned bits, including 2^(WIDTH-1) for the most-negative value.
  assign is_signed = (i_control == F_MULT) || (i_control == F_DIV);
  assign mag1 = (is_signed && i_op1[WIDTH-1]) ? -i_op1 : i_op1;
  assign mag2 = (is_signed && i_op2[WIDTH-1]) ? -i_op2 : i_op2;

  // Multiply: work = {partial product, remaining multiplier bits}, shifted right each step.
  assign mul_sum   = {1'b0, work[2*WIDTH-1:WIDTH]} + {1'b0, (work[0] ? opb : {WIDTH{1'b0}})};
  assign mul_next  = {mul_sum, work[WIDTH-1:1]};
  assign mul_final = neg_q ? -mul_next : mul_next;

  // Divide: work = {partial remainder, dividend/quotient bits}; remainder always below divisor.
  assign div_shift = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb};
  assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], work[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
  assign quot_final = neg_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
  assign rem_final  = neg_r ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= S_IDLE;
      count         <= '0;
      opb           <= '0;
      work          <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_div_by_zero <= 1'b0;
      o_hi          <= '0;
      o_lo          <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            case (i_control)
              F_MTHI: o_hi <= i_op1;
              F_MTLO: o_lo <= i_op1;
              F_MULT, F_MULTU: begin
                work   <= {{WIDTH{1'b0}}, mag2};
                opb    <= mag1;
                neg_q  <= is_signed & (i_op1[WIDTH-1] ^ i_op2[WIDTH-1]);
                neg_r  <= 1'b0;
                count  <= CNT_W'(WIDTH);
                o_busy <= 1'b1;
                state  <= S_MUL;
              end
              F_DIV, F_DIVU: begin
                if (i_op2 == '0) begin
                  o_done        <= 1'b1;
                  o_div_by_zero <= 1'b1;
                  state         <= S_FIN;
                end else begin
                  work   <= {{WIDTH{1'b0}}, mag1};
                  opb    <= mag2;
                  neg_q  <= is_signed & (i_op1[WIDTH-1] ^ i_op2[WIDTH-1]);
                  neg_r  <= is_signed & i_op1[WIDTH-1];
                  count  <= CNT_W'(WIDTH);
                  o_busy <= 1'b1;
                  state  <= S_DIV;
                end
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          work <= mul_next;
          if (count == CNT_W'(1)) begin
            {o_hi, o_lo} <= mul_final;
            count        <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b1;
            state        <= S_FIN;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        S_DIV: begin
          work <= div_next;
          if (count == CNT_W'(1)) begin
            o_lo   <= quot_final;
            o_hi   <= rem_final;
            count  <= '0;
            o_busy <= 1'b0;
            o_done <= 1'b1;
            state  <= S_FIN;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        default: begin
          o_done        <= 1'b0;
          o_div_by_zero <= 1'b0;
          state         <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit at WIDTH=32 and WIDTH=8 against an arithmetic reference model.
module tb_muldiv_unit;

  localparam logic [5:0] MULT  = 6'b011000;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIV   = 6'b011010;
  localparam logic [5:0] DIVU  = 6'b011011;
  localparam logic [5:0] MTHI  = 6'b010001;
  localparam logic [5:0] MTLO  = 6'b010011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_a, busy_a, done_a, dbz_a;
  logic [5:0]  ctrl_a;
  logic [31:0] op1_a, op2_a, hi_a, lo_a;
  logic        start_b, busy_b, done_b, dbz_b;
  logic [5:0]  ctrl_b;
  logic [7:0]  op1_b, op2_b, hi_b, lo_b;

  muldiv_unit #(.WIDTH(32)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_control(ctrl_a),
    .i_op1(op1_a), .i_op2(op2_a), .o_busy(busy_a), .o_done(done_a),
    .o_div_by_zero(dbz_a), .o_hi(hi_a), .o_lo(lo_a)
  );

  muldiv_unit #(.WIDTH(8)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_control(ctrl_b),
    .i_op1(op1_b), .i_op2(op2_b), .o_busy(busy_b), .o_done(done_b),
    .o_div_by_zero(dbz_b), .o_hi(hi_b), .o_lo(lo_b)
  );

  int checks = 0;
  int failures = 0;
  logic [63:0] model_hi [2];
  logic [63:0] model_lo [2];

  function automatic logic [63:0] rd_hi(input bit s);
    return s ? 64'(hi_b) : 64'(hi_a);
  endfunction
  function automatic logic [63:0] rd_lo(input bit s);
    return s ? 64'(lo_b) : 64'(lo_a);
  endfunction
  function automatic logic [63:0] rd_busy(input bit s);
    return s ? 64'(busy_b) : 64'(busy_a);
  endfunction
  function automatic logic [63:0] rd_done(input bit s);
    return s ? 64'(done_b) : 64'(done_a);
  endfunction
  function automatic logic [63:0] rd_dbz(input bit s);
    return s ? 64'(dbz_b) : 64'(dbz_a);
  endfunction

  // Reference: signed/unsigned arithmetic on 64-bit integers, masked to the unit width.
  function automatic void model(input int w, input logic [5:0] c, input logic [63:0] a,
                                input logic [63:0] b, inout logic [63:0] hi,
                                inout logic [63:0] lo, output bit dbz);
    logic [63:0] mask = (64'd1 << w) - 64'd1;
    bit sgn = (c == MULT) || (c == DIV);
    longint sa = longint'(a);
    longint sb = longint'(b);
    logic [63:0] p;
    dbz = 1'b0;
    if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
    if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
    case (c)
      MTHI: hi = a & mask;
      MTLO: lo = a & mask;
      MULT, MULTU: begin
        p  = 64'(sa * sb);
        hi = (p >> w) & mask;
        lo = p & mask;
      end
      DIV, DIVU: begin
        if (b == 64'd0) dbz = 1'b1;
        else begin
          lo = 64'(sa / sb) & mask;
          hi = 64'(sa % sb) & mask;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic drive(input bit s, input logic st, input logic [5:0] c,
                       input logic [31:0] a, input logic [31:0] b);
    if (s) begin
      start_b = st; ctrl_b = c; op1_b = a[7:0]; op2_b = b[7:0];
    end else begin
      start_a = st; ctrl_a = c; op1_a = a; op2_a = b;
    end
  endtask

  // Issues one operation, waits (bounded) for done, and checks latency, flags and HI/LO.
  task automatic apply_stimulus(input bit s, input logic [5:0] c, input logic [31:0] a,
                                input logic [31:0] b, input int inject_at, input string tag);
    int w = s ? 8 : 32;
    logic [63:0] mask = (64'd1 << w) - 64'd1;
    logic [63:0] h = model_hi[s];
    logic [63:0] l = model_lo[s];
    bit exp_dbz;
    int busy_cycles = 0;
    int waited = 0;
    model(w, c, 64'(a) & mask, 64'(b) & mask, h, l, exp_dbz);
    model_hi[s] = h;
    model_lo[s] = l;
    @(negedge clk);
    drive(s, 1'b1, c, a, b);
    @(negedge clk);
    drive(s, 1'b0, c, $urandom, $urandom);
    if (c == MTHI || c == MTLO) begin
      check_output({tag, " busy"}, rd_busy(s), 64'd0);
      check_output({tag, " done"}, rd_done(s), 64'd0);
      check_output({tag, " hi"}, rd_hi(s), model_hi[s]);
      check_output({tag, " lo"}, rd_lo(s), model_lo[s]);
      return;
    end
    while (rd_done(s) != 64'd1 && waited < 2 * w + 4) begin
      if (rd_busy(s) == 64'd1) busy_cycles++;
      if (inject_at != 0 && waited == inject_at) drive(s, 1'b1, DIVU, 32'd9, 32'd2);
      else drive(s, 1'b0, c, $urandom, $urandom);
      @(negedge clk);
      waited++;
    end
    drive(s, 1'b0, c, $urandom, $urandom);
    check_output({tag, " done"}, rd_done(s), 64'd1);
    check_output({tag, " busy cycles"}, 64'(busy_cycles), exp_dbz ? 64'd0 : 64'(w));
    check_output({tag, " busy at done"}, rd_busy(s), 64'd0);
    check_output({tag, " dbz"}, rd_dbz(s), 64'(exp_dbz));
    check_output({tag, " hi"}, rd_hi(s), model_hi[s]);
    check_output({tag, " lo"}, rd_lo(s), model_lo[s]);
    @(negedge clk);
    check_output({tag, " done pulse end"}, rd_done(s), 64'd0);
    check_output({tag, " dbz pulse end"}, rd_dbz(s), 64'd0);
  endtask

  initial begin
    logic [5:0] ops [4];
    ops[0] = MULT; ops[1] = MULTU; ops[2] = DIV; ops[3] = DIVU;
    rst = 1'b1;
    drive(1'b0, 1'b0, 6'd0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 6'd0, 32'd0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      model_hi[i] = 64'd0;
      model_lo[i] = 64'd0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_output("reset busy", rd_busy(1'(i)), 64'd0);
      check_output("reset done", rd_done(1'(i)), 64'd0);
      check_output("reset dbz", rd_dbz(1'(i)), 64'd0);
      check_output("reset hi", rd_hi(1'(i)), 64'd0);
      check_output("reset lo", rd_lo(1'(i)), 64'd0);
    end

    apply_stimulus(1'b0, MULT,  32'hFFFFFFFF, 32'h2, 0, "mult -1x2");
    apply_stimulus(1'b0, MULTU, 32'hFFFFFFFF, 32'h2, 0, "multu max x2");
    apply_stimulus(1'b0, DIV,   32'hFFFFFFF9, 32'h2, 0, "div -7/2");
    apply_stimulus(1'b0, DIVU,  32'd100, 32'd7, 0, "divu 100/7");
    apply_stimulus(1'b0, DIV,   32'h80000000, 32'hFFFFFFFF, 0, "div min/-1");
    check_output("div min/-1 lo const", 64'(lo_a), 64'h80000000);
    apply_stimulus(1'b0, MTHI,  32'h1234, 32'h0, 0, "mthi");
    apply_stimulus(1'b0, MTLO,  32'h5678, 32'h0, 0, "mtlo");
    apply_stimulus(1'b0, DIV,   32'd55, 32'd0, 0, "div by zero");
    check_output("dbz hi kept", 64'(hi_a), 64'h1234);
    apply_stimulus(1'b0, MULT,  32'd3, 32'd5, 10, "mult ignore start");
    check_output("ignore start lo const", 64'(lo_a), 64'd15);

    // Reset in the middle of a divide aborts it and clears HI/LO.
    @(negedge clk);
    drive(1'b0, 1'b1, DIVU, 32'd1000, 32'd3);
    @(negedge clk);
    drive(1'b0, 1'b0, DIVU, $urandom, $urandom);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("abort busy", rd_busy(1'b0), 64'd0);
    check_output("abort done", rd_done(1'b0), 64'd0);
    check_output("abort hi", rd_hi(1'b0), 64'd0);
    check_output("abort lo", rd_lo(1'b0), 64'd0);
    for (int i = 0; i < 2; i++) begin
      model_hi[i] = 64'd0;
      model_lo[i] = 64'd0;
    end
    apply_stimulus(1'b0, MULTU, 32'd6, 32'd7, 0, "multu 6x7");

    apply_stimulus(1'b1, MULT, 32'h80, 32'h80, 0, "w8 mult min x min");
    apply_stimulus(1'b1, DIV,  32'h81, 32'h04, 0, "w8 div -127/4");
    apply_stimulus(1'b1, DIV,  32'h80, 32'hFF, 0, "w8 div min/-1");
    apply_stimulus(1'b1, DIVU, 32'hC3, 32'h00, 0, "w8 div by zero");

    for (int i = 0; i < 24; i++) begin
      bit s = 1'($urandom_range(0, 1));
      logic [31:0] a = $urandom;
      logic [31:0] b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
      apply_stimulus(s, ops[$urandom_range(0, 3)], a, b, 0, "random op");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits beside the combinational ALU in the execute stage and handles MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Multiply uses iterative shift-add; divide uses restoring division, one bit per cycle.
- The core stalls on o_busy and reads HI/LO at any time for MFHI/MFLO.

Parameters:
- WIDTH, 32: operand width and HI/LO width. Must be at least 4.
- CNT_W, $clog2(WIDTH)+1: iteration counter width. Derived; do not override.

Ports:
- i_clk, input, 1: clock. All state updates on the rising edge.
- i_rst, input, 1: synchronous active-high reset.
- i_start, input, 1: operation request. Sampled only in IDLE.
- i_control, input, 6: function code. MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MTHI 010001, MTLO 010011.
- i_op1, input, WIDTH: rs operand (multiplicand / dividend / MTHI, MTLO source).
- i_op2, input, WIDTH: rt operand (multiplier / divisor).
- o_busy, output, 1: an iterative operation is in flight.
- o_done, output, 1: one-cycle pulse; HI/LO valid with the new result.
- o_div_by_zero, output, 1: one-cycle pulse, coincident with o_done, when a DIV/DIVU divisor was 0.
- o_hi, output, WIDTH: HI register.
- o_lo, output, WIDTH: LO register.

Behaviour:
- Reset (i_rst=1 at an edge):
  - state=IDLE; o_hi=0, o_lo=0, o_busy=0, o_done=0, o_div_by_zero=0; counter=0.
  - Reset has priority over everything, including an in-flight operation: that operation is aborted and nothing is written.
- States: IDLE, MUL, DIV, FIN.
- IDLE with i_start=1 at edge k:
  - MTHI / MTLO: o_hi / o_lo <= i_op1 at edge k. No busy, no done. State stays IDLE.
  - MULT/MULTU: latch operands. Signed variant latches magnitudes plus result sign = op1[MSB]^op2[MSB]. Go to MUL, counter=WIDTH, o_busy=1 from edge k.
  - DIV/DIVU with i_op2 != 0: latch magnitudes, quotient sign and remainder sign (= dividend sign for DIV; positive for DIVU). Go to DIV, counter=WIDTH, o_busy=1.
  - DIV/DIVU with i_op2 == 0: go to FIN with a divide-by-zero flag set. o_busy stays 0. HI/LO are not modified.
  - Any other i_control: ignored; remain in IDLE.
- MUL / DIV:
  - One iteration per edge; counter decrements each edge.
  - When counter reaches 1, that edge also applies sign correction (two's-complement negate of the 2*WIDTH product, or of quotient/remainder as flagged), writes HI/LO, sets o_busy=0 and o_done=1, and goes to FIN.
  - Result on edge k+WIDTH: WIDTH cycles of o_busy, then o_done.
- FIN (one cycle):
  - o_done=1. o_div_by_zero=1 only for the zero-divisor case; for that case FIN is entered at edge k and o_done is visible in the cycle after edge k.
  - Next edge: o_done=0, o_div_by_zero=0, return to IDLE.
  - i_start in FIN is ignored.
- i_start while o_busy=1 is ignored. The core must stall. Operands are not re-sampled; i_op1/i_op2 may change freely after the start edge.
- Results:
  - Multiply: {HI,LO} = full 2*WIDTH product.
  - Divide: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
- Boundary: DIV of most-negative by -1 gives LO = 1 followed by WIDTH-1 zeros (wraps), HI=0. No overflow flag.
- Magnitude of the most-negative operand is handled as unsigned 2^(WIDTH-1); the internal datapath is wide enough for it.
- HI/LO hold their values between operations; MFHI/MFLO reads are combinational from o_hi/o_lo.

Test Plan:
- WIDTH=32, reset, then MULT 0xFFFFFFFF x 0x00000002 -> o_busy high for 32 cycles, o_done pulse on the 32nd edge, HI=0xFFFFFFFF, LO=0xFFFFFFFE. Repeat as MULTU -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV -7 (0xFFFFFFF9) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Preload HI=0x1234, LO=0x5678 via MTHI/MTLO, then DIV by 0 -> o_busy never asserts, o_done and o_div_by_zero pulse together one cycle after start, HI/LO remain 0x1234/0x5678.
- Start MULT 3x5; pulse i_start with DIVU 9/2 at cycle 10 and change operands -> DIVU ignored, final HI=0, LO=15 at cycle 32.
- Start DIVU 1000/3; assert i_rst at cycle 12 -> next edge busy=0, done=0, HI=LO=0. A new MULTU 6x7 then completes with LO=42.
- WIDTH=8: MULT 0x80 x 0x80 -> HI=0x40, LO=0x00 after 8 cycles. DIV 0x81 (-127) / 0x04 -> LO=0xE1 (-31), HI=0xFD (-3).
